btn_debouncer: RTL and testbench

- Conditions one raw board pushbutton (BtnC, BtnD, BtnU, BtnL) into clean control strobes for the game cores.
- Sits directly upstream of the start/ack/jump inputs of obstacle_logic, flight_physics and X_RAM_NOREAD, which today take raw buttons.
- Synchronises the asynchronous pin and debounces it with a counter-based FSM.
- Outputs: a level (DPB), a one-cycle press strobe (SCEN), and an auto-repeat strobe (MCEN) for held buttons.
- One instance per button in vga_top, clocked by board_clk.

---
 rtl/btn_pkg.sv | 17 +
 rtl/sync_2ff.sv | 22 ++
 rtl/btn_debouncer.sv | 110 +++++++++++
 tb/tb_btn_debouncer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and
// default debounce/repeat timing at 50 MHz.
package btn_pkg;

    typedef enum logic [2:0] {
        INI     = 3'd0,
        WQ      = 3'd1,
        SCEN_ST = 3'd2,
        CCR     = 3'd3,
        MCEN_ST = 3'd4,
        WFCQ    = 3'd5
    } state_t;

    localparam int unsigned DEB_CYCLES_50M = 1000000;
    localparam int unsigned RPT_CYCLES_50M = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin, synchronous active-high reset.
// Latency 2 cycles; no backpressure (free-running, samples every cycle).
module sync_2ff (
    input  logic Clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Debounces one raw pushbutton into a level (DPB), press strobe (SCEN) and auto-repeat strobe (MCEN).
// Press/release accepted DEB_CYCLES+3 edges after the pin settles; no backpressure, outputs are registered-state decodes.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_50M,
    parameter int unsigned RPT_CYCLES = RPT_CYCLES_50M,
    parameter int unsigned CNT_W      = 25
) (
    input  logic Clk,
    input  logic reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CYCLES - 1);

    logic             pb_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_inc;

    sync_2ff u_sync (
        .Clk   (Clk),
        .reset (reset),
        .d     (PB),
        .q     (pb_s)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= INI;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts on any state change so each timed state measures from its own entry.
    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        case (state)
            INI: begin
                if (pb_s) state_nxt = WQ;
            end
            WQ: begin
                if (!pb_s)                 state_nxt = INI;
                else if (cnt == DEB_LAST)  state_nxt = SCEN_ST;
                else                       cnt_inc   = 1'b1;
            end
            SCEN_ST: begin
                state_nxt = CCR;
            end
            CCR: begin
                if (!pb_s)                 state_nxt = WFCQ;
                else if (cnt == RPT_LAST)  state_nxt = MCEN_ST;
                else                       cnt_inc   = 1'b1;
            end
            MCEN_ST: begin
                state_nxt = CCR;
            end
            WFCQ: begin
                if (pb_s)                  state_nxt = CCR;
                else if (cnt == DEB_LAST)  state_nxt = INI;
                else                       cnt_inc   = 1'b1;
            end
            default: begin
                state_nxt = INI;
            end
        endcase
    end

    always_comb begin
        DPB  = 1'b0;
        SCEN = 1'b0;
        MCEN = 1'b0;
        case (state)
            SCEN_ST: begin
                DPB  = 1'b1;
                SCEN = 1'b1;
                MCEN = 1'b1;
            end
            MCEN_ST: begin
                DPB  = 1'b1;
                MCEN = 1'b1;
            end
            CCR, WFCQ: begin
                DPB = 1'b1;
            end
            default: begin
                DPB = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer: directed scenarios plus random pin activity
// compared every cycle against a timestamp-based reference of the debounce rules.
module tb_btn_debouncer;

    localparam int DEB = 4;
    localparam int RPT = 8;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    logic PB    = 1'b0;
    logic DPB, SCEN, MCEN;

    always #5 Clk = ~Clk;

    btn_debouncer #(
        .DEB_CYCLES (DEB),
        .RPT_CYCLES (RPT),
        .CNT_W      (4)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .PB    (PB),
        .DPB   (DPB),
        .SCEN  (SCEN),
        .MCEN  (MCEN)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: pin is seen two edges late; timing is measured from anchor edges.
    int t = 0;
    bit s1, s2;
    bit pressed, releasing;
    int strobe;       // 0 none, 1 press strobe, 2 repeat strobe
    int a_idle, h_rep, l_rel;

    task automatic model_edge(input bit rst, input bit pb);
        bit d;
        t++;
        if (rst) begin
            s1 = 0; s2 = 0;
            pressed = 0; releasing = 0; strobe = 0;
            a_idle = t;
        end else begin
            d  = s2;
            s2 = s1;
            s1 = pb;
            if (strobe != 0) begin
                strobe    = 0;
                releasing = 0;
                h_rep     = t;
            end else if (!pressed) begin
                if (!d) a_idle = t;
                else if (t - a_idle == DEB + 1) begin
                    pressed = 1;
                    strobe  = 1;
                end
            end else if (!releasing) begin
                if (!d) begin
                    releasing = 1;
                    l_rel     = t;
                end else if (t - h_rep == RPT) begin
                    strobe = 2;
                end
            end else begin
                if (d) begin
                    releasing = 0;
                    h_rep     = t;
                end else if (t - l_rel == DEB) begin
                    pressed   = 0;
                    releasing = 0;
                    a_idle    = t;
                end
            end
        end
    endtask

    int scen_cnt, mcen_cnt, dpb_cnt;

    task automatic step(input bit rst, input bit pb);
        reset = rst;
        PB    = pb;
        @(posedge Clk);
        model_edge(rst, pb);
        #1;
        check("dpb",  DPB,  32'(pressed));
        check("scen", SCEN, 32'(strobe == 1));
        check("mcen", MCEN, 32'(strobe != 0));
        if (SCEN === 1'b1) scen_cnt++;
        if (MCEN === 1'b1) mcen_cnt++;
        if (DPB === 1'b1)  dpb_cnt++;
    endtask

    int lat, first_mcen, mcen_in_hold, dpb_low;
    int seg, pbv;

    initial begin
        step(1, 0);
        step(1, 0);
        check("reset_dpb", DPB, 0);
        check("reset_scen", SCEN, 0);
        check("reset_mcen", MCEN, 0);
        step(0, 0);

        // Clean press
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1);
            if (SCEN === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("press_latency", lat, 7);
        check("press_mcen", MCEN, 1);

        // Hold 40 cycles after the press strobe
        scen_cnt = 0; mcen_cnt = 0; first_mcen = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 1);
            if (MCEN === 1'b1 && first_mcen == 0) first_mcen = i;
        end
        mcen_in_hold = mcen_cnt;
        check("hold_first_repeat", first_mcen, 9);
        check("hold_repeats", mcen_in_hold, 4);
        check("hold_no_scen", scen_cnt, 0);

        // Short release bounce, then hold again
        scen_cnt = 0; dpb_cnt = 0;
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < 12; i++) step(0, 1);
        check("rel_bounce_dpb", dpb_cnt, 14);
        check("rel_bounce_scen", scen_cnt, 0);

        // Full release
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0);
            if (DPB === 1'b0) begin
                lat = i;
                break;
            end
        end
        check("release_latency", lat, 7);
        for (int i = 0; i < 4; i++) step(0, 0);

        // Press bounce: 3 high, 1 low, 3 high, then low
        scen_cnt = 0; mcen_cnt = 0; dpb_cnt = 0;
        for (int i = 0; i < 3; i++) step(0, 1);
        step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 10; i++) step(0, 0);
        check("bounce_scen", scen_cnt, 0);
        check("bounce_mcen", mcen_cnt, 0);
        check("bounce_dpb", dpb_cnt, 0);

        // Reset while held in the repeat-wait state
        for (int i = 0; i < 10; i++) step(0, 1);
        step(1, 1);
        check("midreset_dpb", DPB, 0);
        check("midreset_scen", SCEN, 0);
        check("midreset_mcen", MCEN, 0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1);
            if (SCEN === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("post_reset_latency", lat, 7);
        for (int i = 0; i < 12; i++) step(0, 0);

        // Two presses 20 cycles apart
        scen_cnt = 0;
        for (int i = 0; i < 10; i++) step(0, 1);
        for (int i = 0; i < 10; i++) step(0, 0);
        for (int i = 0; i < 10; i++) step(0, 1);
        for (int i = 0; i < 12; i++) step(0, 0);
        check("two_presses", scen_cnt, 2);

        // Random pin activity with occasional reset
        for (int n = 0; n < 400; n++) begin
            seg = $urandom_range(14, 1);
            pbv = $urandom_range(1, 0);
            if ($urandom_range(60, 0) == 0) step(1, pbv[0]);
            for (int i = 0; i < seg; i++) step(0, pbv[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
